ttl_latch_load_seq: RTL and testbench

- Sequencer that loads a wide word into a bank of NLATCH quad-D latch instances (74175 sync models) over one shared 4-bit D bus. Each latch has its own clock-enable; a common clear line serves the whole bank.
- Produces glitch-free, rising-edge-detectable Cen strobes with guaranteed low/high widths, one latch at a time, in ascending index order.
- Takes requests from a CPU/glue-logic side through a Req/Ack handshake. Sits between the bus decode and the latch bank in the video/sound register sections.

---
 rtl/ttl_latch_load_seq.sv | 177 +++++++++++++++++
 tb/tb_ttl_latch_load_seq.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ttl_latch_load_seq.sv
// Load sequencer for a bank of 74175-style quad latches sharing one nibble bus.
// Strobes each selected latch's clock enable in ascending order, or clears the whole bank.
module ttl_latch_load_seq #(
    parameter int NLATCH   = 4,
    parameter int PULSE_LO = 2,
    parameter int PULSE_HI = 2,
    parameter int CLR_CYC  = 2
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  Req,
    input  logic [4*NLATCH-1:0]   Data,
    input  logic [NLATCH-1:0]     Mask,
    input  logic                  ClrReq,
    output logic                  Busy,
    output logic                  Ack,
    output logic [3:0]            Lat_D,
    output logic [NLATCH-1:0]     Lat_Cen,
    output logic                  Lat_Clr_n
);

    localparam int IDXW = (NLATCH > 1) ? $clog2(NLATCH) : 1;
    localparam int MAXC = (PULSE_LO > PULSE_HI)
                        ? ((PULSE_LO > CLR_CYC) ? PULSE_LO : CLR_CYC)
                        : ((PULSE_HI > CLR_CYC) ? PULSE_HI : CLR_CYC);
    localparam int CNTW = $clog2(MAXC + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_STROBE = 3'd2,
        S_CLEAR  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                r_state;
    logic [CNTW-1:0]       r_cnt;
    logic [IDXW-1:0]       r_idx;
    logic [4*NLATCH-1:0]   r_data;
    logic [NLATCH-1:0]     r_pend;
    logic                  r_busy;
    logic                  r_ack;
    logic [3:0]            r_lat_d;
    logic [NLATCH-1:0]     r_cen;
    logic                  r_clr_n;

    logic [IDXW-1:0]       w_cap_idx;
    logic [NLATCH-1:0]     w_pend_rest;
    logic [IDXW-1:0]       w_next_idx;

    function automatic logic [IDXW-1:0] lowest_bit(input logic [NLATCH-1:0] m);
        logic [IDXW-1:0] r;
        r = '0;
        for (int i = NLATCH - 1; i >= 0; i--) begin
            if (m[i]) r = IDXW'(i);
        end
        return r;
    endfunction

    function automatic logic [NLATCH-1:0] onehot(input logic [IDXW-1:0] idx);
        logic [NLATCH-1:0] r;
        r = '0;
        for (int i = 0; i < NLATCH; i++) begin
            if (IDXW'(i) == idx) r[i] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic [3:0] nibble(input logic [4*NLATCH-1:0] d, input logic [IDXW-1:0] idx);
        logic [3:0] r;
        r = 4'h0;
        for (int i = 0; i < NLATCH; i++) begin
            if (IDXW'(i) == idx) r = d[i*4 +: 4];
        end
        return r;
    endfunction

    // Pending mask with the latch just strobed removed; its lowest bit is the next target.
    assign w_cap_idx   = lowest_bit(Mask);
    assign w_pend_rest = r_pend & ~onehot(r_idx);
    assign w_next_idx  = lowest_bit(w_pend_rest);

    // Sequencer FSM with all outputs registered alongside the state.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_data  <= '0;
            r_pend  <= '0;
            r_busy  <= 1'b0;
            r_ack   <= 1'b0;
            r_lat_d <= 4'h0;
            r_cen   <= '0;
            r_clr_n <= 1'b1;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (ClrReq) begin
                        r_state <= S_CLEAR;
                        r_busy  <= 1'b1;
                        r_clr_n <= 1'b0;
                        r_cnt   <= CNTW'(CLR_CYC);
                    end else if (Req) begin
                        r_data <= Data;
                        r_pend <= Mask;
                        r_busy <= 1'b1;
                        if (Mask == '0) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state <= S_SETUP;
                            r_idx   <= w_cap_idx;
                            r_lat_d <= nibble(Data, w_cap_idx);
                            r_cnt   <= CNTW'(PULSE_LO);
                        end
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_SETUP: begin
                    if (r_cnt == CNTW'(1)) begin
                        r_state <= S_STROBE;
                        r_cen   <= onehot(r_idx);
                        r_cnt   <= CNTW'(PULSE_HI);
                    end else begin
                        r_cnt <= r_cnt - CNTW'(1);
                    end
                end
                S_STROBE: begin
                    if (r_cnt == CNTW'(1)) begin
                        r_cen  <= '0;
                        r_pend <= w_pend_rest;
                        if (w_pend_rest != '0) begin
                            r_state <= S_SETUP;
                            r_idx   <= w_next_idx;
                            r_lat_d <= nibble(r_data, w_next_idx);
                            r_cnt   <= CNTW'(PULSE_LO);
                        end else begin
                            r_state <= S_DONE;
                        end
                    end else begin
                        r_cnt <= r_cnt - CNTW'(1);
                    end
                end
                S_CLEAR: begin
                    if (r_cnt == CNTW'(1)) begin
                        r_clr_n <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - CNTW'(1);
                    end
                end
                S_DONE: begin
                    r_ack   <= 1'b1;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                    r_idx   <= '0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_cen   <= '0;
                    r_clr_n <= 1'b1;
                end
            endcase
        end
    end

    assign Busy      = r_busy;
    assign Ack       = r_ack;
    assign Lat_D     = r_lat_d;
    assign Lat_Cen   = r_cen;
    assign Lat_Clr_n = r_clr_n;

endmodule

// File: tb/tb_ttl_latch_load_seq.sv
// Bench for ttl_latch_load_seq: directed table, corner sequences and random
// transactions checked against a 74175 bank model and a transaction-level reference.
module tb_ttl_latch_load_seq;

    localparam int NL = 4;
    localparam int LO = 2;
    localparam int HI = 2;
    localparam int CC = 2;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Req = 1'b0;
    logic        ClrReq = 1'b0;
    logic [15:0] Data = 16'h0;
    logic [3:0]  Mask = 4'h0;
    logic        Busy;
    logic        Ack;
    logic [3:0]  Lat_D;
    logic [3:0]  Lat_Cen;
    logic        Lat_Clr_n;

    int n_cmp = 0;
    int n_fail = 0;

    logic [15:0] bank_q = 16'h0;
    logic [3:0]  bank_cen_d = 4'h0;
    logic [15:0] model_q = 16'h0;

    typedef struct {
        bit          clr;
        logic [15:0] data;
        logic [3:0]  mask;
        int          lat;
        logic [15:0] q;
    } vec_t;

    vec_t tab[7];

    ttl_latch_load_seq #(.NLATCH(NL), .PULSE_LO(LO), .PULSE_HI(HI), .CLR_CYC(CC)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Req(Req), .Data(Data), .Mask(Mask),
        .ClrReq(ClrReq), .Busy(Busy), .Ack(Ack), .Lat_D(Lat_D),
        .Lat_Cen(Lat_Cen), .Lat_Clr_n(Lat_Clr_n)
    );

    always #5 Clk = ~Clk;

    // Quad-latch bank: captures on the first clock that sees Cen high, clears synchronously.
    always @(posedge Clk) begin
        for (int i = 0; i < NL; i++) begin
            if (!Lat_Clr_n) bank_q[i*4 +: 4] <= 4'h0;
            else if (Lat_Cen[i] && !bank_cen_d[i]) bank_q[i*4 +: 4] <= Lat_D;
        end
        bank_cen_d <= Lat_Cen;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic start(input bit clr, input bit req, input logic [15:0] d, input logic [3:0] m);
        ClrReq = clr;
        Req    = req;
        Data   = d;
        Mask   = m;
    endtask

    // Called at a negedge; the next posedge is the accept edge.
    task automatic monitor(input bit clr_mode, input logic [15:0] d, input logic [3:0] m,
                           input bit keep_req, input bit scramble, input int exp_lat,
                           input logic [15:0] exp_q, input string nm);
        int          s_idx[$];
        logic [3:0]  s_d[$];
        int          e_idx[$];
        int          clr_low = 0;
        int          lat = -1;
        bit          busy_ok = 1'b1;
        bit          excl_ok = 1'b1;
        bit          dstab_ok = 1'b1;
        logic [3:0]  prev_cen = Lat_Cen;
        for (int n = 1; n <= 200; n++) begin
            @(posedge Clk);
            @(negedge Clk);
            if (n == 1) check({nm, ".ack_pulse"}, {31'd0, Ack}, 32'd0);
            if ($countones(Lat_Cen) > 1 || (Lat_Cen != 4'h0 && !Lat_Clr_n)) excl_ok = 1'b0;
            if (!Lat_Clr_n) clr_low++;
            for (int i = 0; i < NL; i++) begin
                if (Lat_Cen[i] && !prev_cen[i]) begin
                    s_idx.push_back(i);
                    s_d.push_back(Lat_D);
                end
                if (Lat_Cen[i] && Lat_D != d[i*4 +: 4]) dstab_ok = 1'b0;
            end
            prev_cen = Lat_Cen;
            if (n > 1 && Ack) begin
                lat = n - 1;
                check({nm, ".busy_at_ack"}, {31'd0, Busy}, 32'd0);
                if (!keep_req) Req = 1'b0;
                ClrReq = 1'b0;
                break;
            end
            if (!Busy) busy_ok = 1'b0;
            if (scramble && n == 2) begin
                Data = ~d;
                Mask = ~m;
            end
        end
        if (lat < 0) begin
            Req = 1'b0;
            ClrReq = 1'b0;
        end
        check({nm, ".latency"}, lat, exp_lat);
        check({nm, ".busy"}, {31'd0, busy_ok}, 32'd1);
        check({nm, ".exclusive"}, {31'd0, excl_ok}, 32'd1);
        check({nm, ".d_stable"}, {31'd0, dstab_ok}, 32'd1);
        check({nm, ".clr_cycles"}, clr_low, clr_mode ? CC : 0);
        for (int i = 0; i < NL; i++) if (!clr_mode && m[i]) e_idx.push_back(i);
        check({nm, ".strobe_count"}, s_idx.size(), e_idx.size());
        for (int k = 0; k < s_idx.size() && k < e_idx.size(); k++) begin
            check({nm, ".strobe_idx"}, s_idx[k], e_idx[k]);
            check({nm, ".strobe_d"}, {28'd0, s_d[k]}, {28'd0, d[e_idx[k]*4 +: 4]});
        end
        check({nm, ".bank_q"}, {16'd0, bank_q}, {16'd0, exp_q});
    endtask

    initial begin
        bit          ack_seen;
        bit          quiet;
        bit          found;
        logic [15:0] rd;
        logic [3:0]  rm;
        bit          rc;
        int          rlat;
        logic [15:0] rq;

        tab[0] = '{clr: 1'b0, data: 16'hA5C3, mask: 4'hF, lat: 17, q: 16'hA5C3};
        tab[1] = '{clr: 1'b0, data: 16'h1234, mask: 4'h5, lat: 9,  q: 16'hA2C4};
        tab[2] = '{clr: 1'b0, data: 16'hFFFF, mask: 4'h0, lat: 1,  q: 16'hA2C4};
        tab[3] = '{clr: 1'b1, data: 16'h0000, mask: 4'h0, lat: 3,  q: 16'h0000};
        tab[4] = '{clr: 1'b0, data: 16'h7E81, mask: 4'h8, lat: 5,  q: 16'h7000};
        tab[5] = '{clr: 1'b0, data: 16'hBEEF, mask: 4'h3, lat: 9,  q: 16'h70EF};
        tab[6] = '{clr: 1'b0, data: 16'h0F0F, mask: 4'h6, lat: 9,  q: 16'h7F0F};

        // Reset, release, then ten quiet cycles.
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("rst.busy", {31'd0, Busy}, 32'd0);
        check("rst.ack", {31'd0, Ack}, 32'd0);
        check("rst.cen", {28'd0, Lat_Cen}, 32'd0);
        check("rst.clr_n", {31'd0, Lat_Clr_n}, 32'd1);
        check("rst.lat_d", {28'd0, Lat_D}, 32'd0);
        Reset_n = 1'b1;
        quiet = 1'b1;
        repeat (10) begin
            @(negedge Clk);
            if (Lat_Cen != 4'h0 || !Lat_Clr_n || Busy || Ack) quiet = 1'b0;
        end
        check("rst.quiet", {31'd0, quiet}, 32'd1);
        check("rst.bank_q", {16'd0, bank_q}, 32'd0);

        // Directed table.
        for (int t = 0; t < 7; t++) begin
            start(tab[t].clr, !tab[t].clr, tab[t].data, tab[t].mask);
            monitor(tab[t].clr, tab[t].data, tab[t].mask, 1'b0, 1'b0, tab[t].lat, tab[t].q,
                    $sformatf("tab%0d", t));
            model_q = tab[t].q;
            @(negedge Clk);
        end

        // Simultaneous Req and ClrReq: clear first, then held Req loads with Data disturbed.
        start(1'b1, 1'b1, 16'h5A69, 4'hF);
        monitor(1'b1, 16'h5A69, 4'hF, 1'b1, 1'b0, 1 + CC, 16'h0000, "both.clr");
        monitor(1'b0, 16'h5A69, 4'hF, 1'b0, 1'b1, 1 + 4 * (LO + HI), 16'h5A69, "both.load");
        model_q = 16'h5A69;
        @(negedge Clk);

        // Reset during the strobe of latch 1 aborts without Ack.
        start(1'b0, 1'b1, 16'h3C96, 4'hF);
        found = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge Clk);
            if (Lat_Cen[1]) begin
                found = 1'b1;
                break;
            end
        end
        check("abort.reach_strobe1", {31'd0, found}, 32'd1);
        Reset_n = 1'b0;
        Req = 1'b0;
        @(negedge Clk);
        check("abort.cen", {28'd0, Lat_Cen}, 32'd0);
        check("abort.busy", {31'd0, Busy}, 32'd0);
        check("abort.ack", {31'd0, Ack}, 32'd0);
        check("abort.clr_n", {31'd0, Lat_Clr_n}, 32'd1);
        Reset_n = 1'b1;
        ack_seen = 1'b0;
        repeat (20) begin
            @(negedge Clk);
            if (Ack || Busy || Lat_Cen != 4'h0) ack_seen = 1'b1;
        end
        check("abort.idle_after", {31'd0, ack_seen}, 32'd0);
        model_q[7:0] = 8'h96;
        check("abort.bank_q", {16'd0, bank_q}, {16'd0, model_q});
        start(1'b0, 1'b1, 16'hD08B, 4'hF);
        monitor(1'b0, 16'hD08B, 4'hF, 1'b0, 1'b0, 17, 16'hD08B, "abort.reload");
        model_q = 16'hD08B;

        // Random transactions against the transaction-level reference.
        for (int r = 0; r < 40; r++) begin
            repeat ($urandom_range(0, 3)) @(negedge Clk);
            rc = ($urandom_range(0, 4) == 0);
            rd = 16'($urandom);
            rm = 4'($urandom_range(0, 15));
            if (rc) begin
                rlat = 1 + CC;
                rq = 16'h0;
            end else begin
                rlat = 1 + $countones(rm) * (LO + HI);
                rq = model_q;
                for (int i = 0; i < NL; i++) if (rm[i]) rq[i*4 +: 4] = rd[i*4 +: 4];
            end
            start(rc, !rc, rd, rm);
            monitor(rc, rd, rm, 1'b0, 1'($urandom_range(0, 1)), rlat, rq, $sformatf("rnd%0d", r));
            model_q = rq;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
